mem_dump_ctrl: RTL
==================

MEM_DUMP_CTRL -- requirements
Module: mem_dump_ctrl

Interface
REQ-001 SHALL have parameter NB_DEPTH, default 8, data memory address width; RAM_DEPTH = 2**NB_DEPTH words.
REQ-002 SHALL have parameter NB_DATA, default 32, memory word width; must equal 4*NB_BYTE.
REQ-003 SHALL have parameter NB_BYTE, default 8, transmit byte width.
REQ-004 SHALL use one clock and an asynchronous, active-high reset: i_clk and i_rst.
REQ-005 SHALL have port i_clk  input  1  system clock, rising edge.
REQ-006 SHALL have port i_rst  input  1  asynchronous active-high reset.
REQ-007 SHALL have port i_start  input  1  one-cycle request to begin a dump.
REQ-008 SHALL have port i_mem_data  input  NB_DATA  registered debug read word from data memory.
REQ-009 SHALL have port i_tx_ready  input  1  byte sink ready.
REQ-010 SHALL have port o_addr_debug  output  NB_DEPTH  debug read address to data memory.
REQ-011 SHALL have port o_mem_sel  output  1  drives memory debug-enable; 1 = pipeline read path owns port, 0 = dump path owns port.
REQ-012 SHALL have port o_tx_data  output  NB_BYTE  byte to sink.
REQ-013 SHALL have port o_tx_valid  output  1  o_tx_data valid.
REQ-014 SHALL have port o_busy  output  1  dump in progress.
REQ-015 SHALL have port o_done  output  1  one-cycle pulse at dump completion.

Function
REQ-016 SHALL implement states IDLE, HEADER, READ, LATCH, SEND, DONE.
REQ-017 In IDLE, i_start=1 at an edge SHALL clear address and byte counter, set o_mem_sel=0, o_busy=1, and enter HEADER (macro defined) or READ.
REQ-018 READ SHALL last exactly one cycle with o_addr_debug stable; next state LATCH.
REQ-019 LATCH SHALL load i_mem_data into a shift register, clear byte counter; next state SEND.
REQ-020 o_tx_valid SHALL be 1 exactly in HEADER and SEND, decoded from state.
REQ-021 A byte transfers at an edge where o_tx_valid=1 and i_tx_ready=1; while o_tx_valid=1 and i_tx_ready=0, o_tx_data SHALL hold.
REQ-022 SEND SHALL emit word bytes LSB first: [7:0], [15:8], [23:16], [31:24].
REQ-023 After the 4th transfer: address < RAM_DEPTH-1 -> address+1, READ; address = RAM_DEPTH-1 -> DONE (no wrap).
REQ-024 DONE SHALL last one cycle with o_done=1, then IDLE with o_mem_sel=1, o_busy=0, address unchanged.
REQ-025 i_start SHALL be ignored in every state except IDLE.
REQ-026 o_mem_sel SHALL be 0 in every non-IDLE state, including DONE.
REQ-027 Total bytes per dump SHALL be 4*RAM_DEPTH, plus 1 with header.
REQ-028 Without stalls, first data byte valid SHALL appear 3 cycles after the start edge (READ, LATCH, SEND).

Reset
REQ-029 i_rst=1 SHALL immediately force IDLE, o_addr_debug=0, o_mem_sel=1, o_tx_data=0, o_tx_valid=0, o_busy=0, o_done=0, counters 0.
REQ-030 Reset asserted mid-dump SHALL abort with no further bytes; a new i_start after release SHALL restart at address 0.

Configuration
REQ-031 Macro MEM_DUMP_HEADER_EN defined: HEADER presents sync byte 8'hA5 with full handshake, then READ.
REQ-032 MEM_DUMP_HEADER_EN undefined: HEADER state and sync byte absent; IDLE goes directly to READ.

Verification
REQ-033 NB_DEPTH=2, memory words 32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00, i_tx_ready=1 -> bytes 44,33,22,11,88,77,66,55,CC,BB,AA,99,00,FF,EE,DD, one o_done pulse, o_mem_sel back to 1.
REQ-034 i_tx_ready low 5 cycles during 2nd byte -> o_tx_data holds 8'h33 and o_tx_valid stays 1 for all 5 cycles; no byte lost or duplicated.
REQ-035 i_start pulsed during SEND of word 1 -> ignored; exactly 16 bytes, one o_done.
REQ-036 i_rst asserted after 6 bytes -> outputs at reset values within the same cycle; restart emits 16 bytes from address 0.
REQ-037 MEM_DUMP_HEADER_EN defined, same data as REQ-033 -> 8'hA5 first, then the 16 bytes (17 total).

Source files
------------

// File: rtl/mem_dump_ctrl.sv
// mem_dump_ctrl: streams the whole data memory out as bytes, LSB first, over a
// valid/ready byte interface, borrowing the memory debug read port meanwhile.
// Build option: define MEM_DUMP_HEADER_EN to prefix each dump with sync byte 8'hA5.
module mem_dump_ctrl #(
  parameter int NB_DEPTH = 8,
  parameter int NB_DATA  = 32,
  parameter int NB_BYTE  = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [NB_DATA-1:0]  i_mem_data,
  input  logic                i_tx_ready,
  output logic [NB_DEPTH-1:0] o_addr_debug,
  output logic                o_mem_sel,
  output logic [NB_BYTE-1:0]  o_tx_data,
  output logic                o_tx_valid,
  output logic                o_busy,
  output logic                o_done
);

  localparam int                  RAM_DEPTH = 2 ** NB_DEPTH;
  localparam logic [NB_DEPTH-1:0] LAST_ADDR = NB_DEPTH'(RAM_DEPTH - 1);
`ifdef MEM_DUMP_HEADER_EN
  localparam logic [NB_BYTE-1:0]  SYNC_BYTE = NB_BYTE'(8'hA5);
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
`ifdef MEM_DUMP_HEADER_EN
    HEADER = 3'd1,
`endif
    READ   = 3'd2,
    LATCH  = 3'd3,
    SEND   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [NB_DEPTH-1:0] addr_q, addr_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [NB_DATA-1:0]  shift_q;

  // Control registers: state, read address and byte-within-word counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Word shifter: captured in LATCH, moves down one byte per accepted transfer.
  always_ff @(posedge i_clk) begin
    if (state_q == LATCH) begin
      shift_q <= i_mem_data;
    end else if (state_q == SEND && i_tx_ready) begin
      shift_q <= shift_q >> NB_BYTE;
    end
  end

  // Next-state and output decode; all outputs follow directly from state.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    o_mem_sel  = 1'b0;
    o_busy     = 1'b1;
    o_done     = 1'b0;
    o_tx_valid = 1'b0;
    o_tx_data  = '0;
    case (state_q)
      IDLE: begin
        o_mem_sel = 1'b1;
        o_busy    = 1'b0;
        if (i_start) begin
          addr_d = '0;
          cnt_d  = '0;
`ifdef MEM_DUMP_HEADER_EN
          state_d = HEADER;
`else
          state_d = READ;
`endif
        end
      end
`ifdef MEM_DUMP_HEADER_EN
      HEADER: begin
        o_tx_valid = 1'b1;
        o_tx_data  = SYNC_BYTE;
        if (i_tx_ready) state_d = READ;
      end
`endif
      // Address is held for this cycle; the memory registers the word at its end.
      READ: state_d = LATCH;
      LATCH: begin
        cnt_d   = '0;
        state_d = SEND;
      end
      SEND: begin
        o_tx_valid = 1'b1;
        o_tx_data  = shift_q[NB_BYTE-1:0];
        if (i_tx_ready) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (addr_q == LAST_ADDR) begin
              state_d = DONE;
            end else begin
              addr_d  = addr_q + NB_DEPTH'(1);
              state_d = READ;
            end
          end
        end
      end
      DONE: begin
        o_done  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_addr_debug = addr_q;

endmodule
